// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared definitions for the SDRAM word-port arbiter: FSM state
//               encodings, default sizes, requester indices and the
//               round-robin / writeback-first winner selection.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

  // Arbiter FSM state encodings
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] GRANT  = 3'd1;
  localparam logic [2:0] STROBE = 3'd2;
  localparam logic [2:0] GAP    = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  // Default geometry: 32-word blocks, 11-bit block address
  localparam int DEF_BLOCKSIZE_W = 5;
  localparam int DEF_BADDR_W     = 11;

  // Requester indices
  localparam logic REQ_P0 = 1'b0;
  localparam logic REQ_P1 = 1'b1;

  // Returns the winning requester index. A lone requester always wins. On a
  // tie the writer wins when wb_first is set and exactly one side writes;
  // otherwise the port that was not granted last wins.
  function automatic logic arb_pick(input logic req0, input logic req1,
                                    input logic wr0, input logic wr1,
                                    input logic last, input logic wb_first);
    logic pick;
    pick = ~last;
    if (req0 && !req1) begin
      pick = REQ_P0;
    end else if (req1 && !req0) begin
      pick = REQ_P1;
    end else if (wb_first && (wr0 ^ wr1)) begin
      pick = wr1 ? REQ_P1 : REQ_P0;
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Requester handshake and SDRAM word-port bundle. The master
//               modport is the requester / memory side, the slave modport is
//               the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if
  import cache_pkg::*;
#(
  parameter int BLOCKSIZE_W = DEF_BLOCKSIZE_W,
  parameter int BADDR_W     = DEF_BADDR_W
) ();

  logic                           req0;
  logic                           req1;
  logic                           wr0;
  logic                           wr1;
  logic [BADDR_W-1:0]             baddr0;
  logic [BADDR_W-1:0]             baddr1;
  logic                           gnt0;
  logic                           gnt1;
  logic                           done0;
  logic                           done1;
  logic [BADDR_W+BLOCKSIZE_W-1:0] sdram_addr;
  logic [BLOCKSIZE_W-1:0]         word_offset;
  logic                           wr_rd_sdram;
  logic                           memstrb;
  logic                           busy;

  modport master (
    output req0, req1, wr0, wr1, baddr0, baddr1,
    input  gnt0, gnt1, done0, done1, sdram_addr, word_offset,
    input  wr_rd_sdram, memstrb, busy
  );

  modport slave (
    input  req0, req1, wr0, wr1, baddr0, baddr1,
    output gnt0, gnt1, done0, done1, sdram_addr, word_offset,
    output wr_rd_sdram, memstrb, busy
  );

endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_burst_offset_counter.sv
`default_nettype none
// ============================================================================
// Module      : burst_offset_counter
// Description : Word index within a block burst. Synchronous clear, enabled
//               increment, and a flag for the final word of the block.
// Revision    : 1.0 - initial release
// ============================================================================
module burst_offset_counter
  import cache_pkg::*;
#(
  parameter int BLOCKSIZE_W = DEF_BLOCKSIZE_W
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  input  wire logic                   clr_i,
  input  wire logic                   inc_i,
  output logic [BLOCKSIZE_W-1:0]      offset_o,
  output logic                        last_o
);

  logic [BLOCKSIZE_W-1:0] offset_q;

  // Offset register: clear dominates increment
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      offset_q <= '0;
    end else if (inc_i) begin
      offset_q <= offset_q + {{(BLOCKSIZE_W-1){1'b0}}, 1'b1};
    end
  end

  assign offset_o = offset_q;
  assign last_o   = (offset_q == {BLOCKSIZE_W{1'b1}});

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Two-requester round-robin arbiter for the SDRAM word port.
//               Grants one owner and sequences a 2^BLOCKSIZE_W word burst as
//               alternating STROBE/GAP cycles, then pulses done to the owner.
//               Optional macro MEM_ARB_WB_FIRST_EN: on a tie where exactly one
//               side writes, the writer wins (dirty writeback before fill).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import cache_pkg::*;
#(
  parameter int BLOCKSIZE_W = DEF_BLOCKSIZE_W,
  parameter int BADDR_W     = DEF_BADDR_W
) (
  input wire logic          clk,
  input wire logic          rst,
  mem_port_arbiter_if.slave bus
);

`ifdef MEM_ARB_WB_FIRST_EN
  localparam logic WB_FIRST = 1'b1;
`else
  localparam logic WB_FIRST = 1'b0;
`endif

  logic [2:0]             state_q;
  logic [2:0]             state_d;
  logic                   last_q;     // last-granted port; also the owner during a burst
  logic                   gnt0_q;
  logic                   gnt1_q;
  logic                   done0_q;
  logic                   done1_q;
  logic                   memstrb_q;
  logic                   wr_rd_q;
  logic [BADDR_W-1:0]     baddr_q;
  logic                   winner;
  logic                   ctr_clr;
  logic                   ctr_inc;
  logic                   ctr_last;
  logic [BLOCKSIZE_W-1:0] offset;

  assign winner = arb_pick(bus.req0, bus.req1, bus.wr0, bus.wr1, last_q, WB_FIRST);

  // Offset restarts on GRANT and is parked at zero once the burst finishes
  assign ctr_clr = (state_q == GRANT) || (state_q == DONE);
  assign ctr_inc = (state_q == GAP) && !ctr_last;

  burst_offset_counter #(
    .BLOCKSIZE_W (BLOCKSIZE_W)
  ) u_offset (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (ctr_clr),
    .inc_i    (ctr_inc),
    .offset_o (offset),
    .last_o   (ctr_last)
  );

  // Next-state logic of the burst sequencer
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req0 || bus.req1) state_d = GRANT;
      GRANT:   state_d = STROBE;
      STROBE:  state_d = GAP;
      GAP:     state_d = ctr_last ? DONE : STROBE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, grant latch and registered outputs derived from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= REQ_P1;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      memstrb_q <= 1'b0;
      wr_rd_q   <= 1'b0;
      baddr_q   <= '0;
    end else begin
      state_q   <= state_d;
      memstrb_q <= (state_d == STROBE);
      done0_q   <= (state_d == DONE) && (last_q == REQ_P0);
      done1_q   <= (state_d == DONE) && (last_q == REQ_P1);
      if ((state_q == IDLE) && (state_d == GRANT)) begin
        last_q  <= winner;
        gnt0_q  <= (winner == REQ_P0);
        gnt1_q  <= (winner == REQ_P1);
        baddr_q <= (winner == REQ_P1) ? bus.baddr1 : bus.baddr0;
        wr_rd_q <= (winner == REQ_P1) ? bus.wr1 : bus.wr0;
      end else if (state_d == DONE) begin
        wr_rd_q <= 1'b0;
      end else if (state_d == IDLE) begin
        gnt0_q  <= 1'b0;
        gnt1_q  <= 1'b0;
        baddr_q <= '0;
        wr_rd_q <= 1'b0;
      end
    end
  end

  assign bus.gnt0        = gnt0_q;
  assign bus.gnt1        = gnt1_q;
  assign bus.done0       = done0_q;
  assign bus.done1       = done1_q;
  assign bus.memstrb     = memstrb_q;
  assign bus.wr_rd_sdram = wr_rd_q;
  assign bus.word_offset = offset;
  assign bus.sdram_addr  = {baddr_q, offset};
  assign bus.busy        = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed bench for mem_port_arbiter. Expected strobe
//               addresses are queued when a burst is requested and popped on
//               every observed memstrb; timing of grant/strobe/done is
//               checked cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int BSW = 5;
  localparam int BAW = 11;
  localparam int W   = 1 << BSW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [16:0] sb [$];   // {wr, sdram_addr}

  mem_port_arbiter_if #(.BLOCKSIZE_W(BSW), .BADDR_W(BAW)) bus ();

  mem_port_arbiter #(.BLOCKSIZE_W(BSW), .BADDR_W(BAW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},   {30'd0, bus.gnt1, bus.gnt0}, 0);
    chk({tag, "_done"},  {30'd0, bus.done1, bus.done0}, 0);
    chk({tag, "_strb"},  bus.memstrb, 0);
    chk({tag, "_wrrd"},  bus.wr_rd_sdram, 0);
    chk({tag, "_busy"},  bus.busy, 0);
    chk({tag, "_off"},   bus.word_offset, 0);
    chk({tag, "_addr"},  bus.sdram_addr, 0);
  endtask

  // Called at a negedge with the request already applied and the arbiter
  // idle; follows the burst to the first IDLE cycle after done.
  task automatic burst(input logic p, input logic w, input logic [10:0] ba, input int drop_k);
    logic [16:0] e;
    for (int k = 0; k < W; k++) sb.push_back({w, ba, 5'(k)});
    for (int c = 1; c <= 2*W+3; c++) begin
      @(negedge clk);
      chk("memstrb_timing", bus.memstrb, (c >= 2 && c <= 2*W && (c % 2) == 0));
      if (c == 1) begin
        chk("grant_owner", {30'd0, bus.gnt1, bus.gnt0}, p ? 2 : 1);
        chk("grant_busy", bus.busy, 1);
      end
      if (bus.memstrb === 1'b1) begin
        if (sb.size() == 0) begin
          chk("sb_empty_at_strobe", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("sdram_addr", bus.sdram_addr, e[15:0]);
          chk("word_offset", bus.word_offset, e[4:0]);
          chk("wr_rd_sdram", bus.wr_rd_sdram, e[16]);
          chk("gnt_in_burst", {30'd0, bus.gnt1, bus.gnt0}, p ? 2 : 1);
        end
        if (drop_k > 0 && c == 2*drop_k) begin
          if (p) bus.req1 = 1'b0;
          else   bus.req0 = 1'b0;
        end
      end
      if (c == 2*W+2) begin
        chk("done_owner", {30'd0, bus.done1, bus.done0}, p ? 2 : 1);
        chk("done_wrrd", bus.wr_rd_sdram, 0);
        chk("done_gnt", {30'd0, bus.gnt1, bus.gnt0}, p ? 2 : 1);
      end else begin
        chk("no_done", {30'd0, bus.done1, bus.done0}, 0);
      end
      if (c == 2*W+3) chk_all_zero("idle_after");
    end
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    int nstrb;
    bus.req0 = 0; bus.req1 = 0; bus.wr0 = 0; bus.wr1 = 0;
    bus.baddr0 = '0; bus.baddr1 = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("post_reset");

    // Tie after reset: port 0 first (single read 0x155), then port 1 write
    bus.req0 = 1; bus.wr0 = 0; bus.baddr0 = 11'h155;
    bus.req1 = 1; bus.wr1 = 1; bus.baddr1 = 11'h2AA;
    burst(1'b0, 1'b0, 11'h155, -1);
    burst(1'b1, 1'b1, 11'h2AA, -1);
    // Fairness continues; port 1 drops its request after the 5th strobe
    burst(1'b0, 1'b0, 11'h155, -1);
    burst(1'b1, 1'b1, 11'h2AA, 5);
    // Port 0 alone; last-granted becomes 0
    burst(1'b0, 1'b0, 11'h155, -1);

    // Tie with port 0 writing and port 1 reading, last-granted = 0
    bus.wr0 = 1; bus.baddr0 = 11'h011;
    bus.req1 = 1; bus.wr1 = 0; bus.baddr1 = 11'h7FE;
`ifdef MEM_ARB_WB_FIRST_EN
    burst(1'b0, 1'b1, 11'h011, -1);
`else
    burst(1'b1, 1'b0, 11'h7FE, -1);
`endif
    bus.req0 = 0; bus.req1 = 0; bus.wr0 = 0;
    repeat (3) @(negedge clk);
    chk("quiet_busy", bus.busy, 0);

    // Reset at the 10th strobe of a burst
    bus.req0 = 1; bus.baddr0 = 11'h0F0;
    nstrb = 0;
    for (int c = 0; c < 200 && nstrb < 10; c++) begin
      @(negedge clk);
      if (bus.memstrb === 1'b1) nstrb++;
    end
    chk("reached_10th_strobe", nstrb, 10);
    rst = 1'b1; bus.req0 = 0;
    @(negedge clk);
    chk_all_zero("mid_reset");
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("after_mid_reset");
    bus.req0 = 1;
    burst(1'b0, 1'b0, 11'h0F0, -1);
    bus.req0 = 0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
